// File: rtl/hi_lo_scheduler.sv
// hi_lo_scheduler: sequences the shared multiplier and divider for the EX-stage
// HI/LO instructions and owns the architectural HI and LO registers.
// EX is stalled while a multiply or divide is in flight. A WB flush abandons
// in-flight work, and a divide in flight is cancelled at the divider.
module hi_lo_scheduler #(
  parameter int CPU_DATA_WIDTH   = 32,
  parameter int MULTIPLY_LATENCY = 2
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          request_valid,
  input  logic [2:0]                    request_op,
  input  logic [CPU_DATA_WIDTH-1:0]     source1,
  input  logic [CPU_DATA_WIDTH-1:0]     source2,
  input  logic                          flush,
  output logic                          stall,
  output logic [CPU_DATA_WIDTH-1:0]     move_result,
  output logic                          multiplier_valid,
  output logic                          multiplier_signed,
  output logic [CPU_DATA_WIDTH-1:0]     multiplier_source1,
  output logic [CPU_DATA_WIDTH-1:0]     multiplier_source2,
  input  logic [2*CPU_DATA_WIDTH-1:0]   multiplier_result,
  output logic                          divider_start,
  output logic                          divider_cancel,
  output logic                          divider_signed,
  output logic [CPU_DATA_WIDTH-1:0]     divider_dividend,
  output logic [CPU_DATA_WIDTH-1:0]     divider_divisor,
  input  logic                          divider_done,
  input  logic [CPU_DATA_WIDTH-1:0]     divider_quotient,
  input  logic [CPU_DATA_WIDTH-1:0]     divider_remainder,
  output logic [CPU_DATA_WIDTH-1:0]     hi,
  output logic [CPU_DATA_WIDTH-1:0]     lo
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MFHI  = 3'd6;
  localparam logic [2:0] OP_MFLO  = 3'd7;

  // The counter holds MULTIPLY_LATENCY-1 down to 0.
  localparam int CNT_W = (MULTIPLY_LATENCY > 1) ? $clog2(MULTIPLY_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULTIPLY_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  typedef enum logic [1:0] {
    IDLE          = 2'd0,
    MULTIPLY_WAIT = 2'd1,
    DIVIDE_WAIT   = 2'd2
  } state_t;

  state_t                    state_r, state_next_s;
  logic [CPU_DATA_WIDTH-1:0] hi_r, hi_next_s;
  logic [CPU_DATA_WIDTH-1:0] lo_r, lo_next_s;
  logic [CNT_W-1:0]          counter_r, counter_next_s;
  // Set on the completion edge so the re-presented instruction is consumed, not re-issued.
  logic                      done_r, done_next_s;
  logic                      mul_valid_r, mul_valid_next_s;
  logic                      mul_signed_r, mul_signed_next_s;
  logic [CPU_DATA_WIDTH-1:0] mul_src1_r, mul_src1_next_s;
  logic [CPU_DATA_WIDTH-1:0] mul_src2_r, mul_src2_next_s;
  logic                      div_start_r, div_start_next_s;
  logic                      div_cancel_r, div_cancel_next_s;
  logic                      div_signed_r, div_signed_next_s;
  logic [CPU_DATA_WIDTH-1:0] div_dividend_r, div_dividend_next_s;
  logic [CPU_DATA_WIDTH-1:0] div_divisor_r, div_divisor_next_s;
  logic                      is_muldiv_s;
  logic                      stall_s;
  logic [CPU_DATA_WIDTH-1:0] move_result_s;

  // Decode whether the request needs the multiplier or the divider.
  always_comb begin
    is_muldiv_s = 1'b0;
    if ((request_op == OP_MULT) || (request_op == OP_MULTU) ||
        (request_op == OP_DIV)  || (request_op == OP_DIVU)) begin
      is_muldiv_s = 1'b1;
    end else begin
      is_muldiv_s = 1'b0;
    end
  end

  // Next-state, HI/LO update and unit-issue decisions.
  always_comb begin
    state_next_s        = state_r;
    hi_next_s           = hi_r;
    lo_next_s           = lo_r;
    counter_next_s      = counter_r;
    done_next_s         = done_r;
    mul_valid_next_s    = 1'b0;
    mul_signed_next_s   = mul_signed_r;
    mul_src1_next_s     = mul_src1_r;
    mul_src2_next_s     = mul_src2_r;
    div_start_next_s    = 1'b0;
    div_cancel_next_s   = 1'b0;
    div_signed_next_s   = div_signed_r;
    div_dividend_next_s = div_dividend_r;
    div_divisor_next_s  = div_divisor_r;
    case (state_r)
      IDLE: begin
        // The flag only ever covers the cycle right after a completion.
        done_next_s = 1'b0;
        if (flush) begin
          state_next_s = IDLE;
        end else if (request_valid) begin
          case (request_op)
            OP_MULT, OP_MULTU: begin
              if (!done_r) begin
                mul_valid_next_s  = 1'b1;
                mul_signed_next_s = (request_op == OP_MULT);
                mul_src1_next_s   = source1;
                mul_src2_next_s   = source2;
                counter_next_s    = CNT_LOAD;
                state_next_s      = MULTIPLY_WAIT;
              end else begin
                state_next_s = IDLE;
              end
            end
            OP_DIV, OP_DIVU: begin
              if (!done_r) begin
                div_start_next_s    = 1'b1;
                div_signed_next_s   = (request_op == OP_DIV);
                div_dividend_next_s = source1;
                div_divisor_next_s  = source2;
                state_next_s        = DIVIDE_WAIT;
              end else begin
                state_next_s = IDLE;
              end
            end
            OP_MTHI: hi_next_s = source1;
            OP_MTLO: lo_next_s = source1;
            // MFHI/MFLO are served combinationally from move_result.
            default: state_next_s = IDLE;
          endcase
        end else begin
          state_next_s = IDLE;
        end
      end
      MULTIPLY_WAIT: begin
        if (flush) begin
          state_next_s = IDLE;
          done_next_s  = 1'b0;
        end else if (counter_r == CNT_ZERO) begin
          hi_next_s    = multiplier_result[2*CPU_DATA_WIDTH-1:CPU_DATA_WIDTH];
          lo_next_s    = multiplier_result[CPU_DATA_WIDTH-1:0];
          done_next_s  = 1'b1;
          state_next_s = IDLE;
        end else begin
          counter_next_s = counter_r - CNT_ONE;
        end
      end
      DIVIDE_WAIT: begin
        if (flush) begin
          div_cancel_next_s = 1'b1;
          done_next_s       = 1'b0;
          state_next_s      = IDLE;
        end else if (divider_done) begin
          hi_next_s    = divider_remainder;
          lo_next_s    = divider_quotient;
          done_next_s  = 1'b1;
          state_next_s = IDLE;
        end else begin
          state_next_s = DIVIDE_WAIT;
        end
      end
      default: begin
        state_next_s = IDLE;
        done_next_s  = 1'b0;
      end
    endcase
  end

  // Stall: EX holds while a multiply/divide is being issued or is in flight.
  always_comb begin
    stall_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (request_valid && !flush && !done_r && is_muldiv_s) begin
          stall_s = 1'b1;
        end else begin
          stall_s = 1'b0;
        end
      end
      MULTIPLY_WAIT, DIVIDE_WAIT: stall_s = 1'b1;
      default: stall_s = 1'b0;
    endcase
  end

  // MFHI/MFLO read the registered HI/LO, which already hold any just-completed result.
  always_comb begin
    move_result_s = '0;
    if (request_valid && (request_op == OP_MFHI)) begin
      move_result_s = hi_r;
    end else if (request_valid && (request_op == OP_MFLO)) begin
      move_result_s = lo_r;
    end else begin
      move_result_s = '0;
    end
  end

  // State, HI/LO and unit-interface registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= IDLE;
      hi_r           <= '0;
      lo_r           <= '0;
      counter_r      <= CNT_ZERO;
      done_r         <= 1'b0;
      mul_valid_r    <= 1'b0;
      mul_signed_r   <= 1'b0;
      mul_src1_r     <= '0;
      mul_src2_r     <= '0;
      div_start_r    <= 1'b0;
      div_cancel_r   <= 1'b0;
      div_signed_r   <= 1'b0;
      div_dividend_r <= '0;
      div_divisor_r  <= '0;
    end else begin
      state_r        <= state_next_s;
      hi_r           <= hi_next_s;
      lo_r           <= lo_next_s;
      counter_r      <= counter_next_s;
      done_r         <= done_next_s;
      mul_valid_r    <= mul_valid_next_s;
      mul_signed_r   <= mul_signed_next_s;
      mul_src1_r     <= mul_src1_next_s;
      mul_src2_r     <= mul_src2_next_s;
      div_start_r    <= div_start_next_s;
      div_cancel_r   <= div_cancel_next_s;
      div_signed_r   <= div_signed_next_s;
      div_dividend_r <= div_dividend_next_s;
      div_divisor_r  <= div_divisor_next_s;
    end
  end

  assign stall              = stall_s;
  assign move_result        = move_result_s;
  assign multiplier_valid   = mul_valid_r;
  assign multiplier_signed  = mul_signed_r;
  assign multiplier_source1 = mul_src1_r;
  assign multiplier_source2 = mul_src2_r;
  assign divider_start      = div_start_r;
  assign divider_cancel     = div_cancel_r;
  assign divider_signed     = div_signed_r;
  assign divider_dividend   = div_dividend_r;
  assign divider_divisor    = div_divisor_r;
  assign hi                 = hi_r;
  assign lo                 = lo_r;

endmodule

// File: tb/tb_hi_lo_scheduler.sv
// Testbench for hi_lo_scheduler: a directed table, hand-written corner sequences
// and random EX traffic, all checked against a transaction-level model of HI/LO.
module tb_hi_lo_scheduler;

  localparam int W   = 32;
  localparam int LAT = 2;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MFHI  = 3'd6;
  localparam logic [2:0] OP_MFLO  = 3'd7;

  logic           clock = 1'b0;
  logic           reset_n;
  logic           request_valid;
  logic [2:0]     request_op;
  logic [W-1:0]   source1, source2;
  logic           flush;
  logic           stall;
  logic [W-1:0]   move_result;
  logic           multiplier_valid, multiplier_signed;
  logic [W-1:0]   multiplier_source1, multiplier_source2;
  logic [2*W-1:0] multiplier_result;
  logic           divider_start, divider_cancel, divider_signed;
  logic [W-1:0]   divider_dividend, divider_divisor;
  logic           divider_done;
  logic [W-1:0]   divider_quotient, divider_remainder;
  logic [W-1:0]   hi, lo;

  always #5 clock = ~clock;

  hi_lo_scheduler #(.CPU_DATA_WIDTH(W), .MULTIPLY_LATENCY(LAT)) dut (
    .clock(clock), .reset_n(reset_n),
    .request_valid(request_valid), .request_op(request_op),
    .source1(source1), .source2(source2), .flush(flush),
    .stall(stall), .move_result(move_result),
    .multiplier_valid(multiplier_valid), .multiplier_signed(multiplier_signed),
    .multiplier_source1(multiplier_source1), .multiplier_source2(multiplier_source2),
    .multiplier_result(multiplier_result),
    .divider_start(divider_start), .divider_cancel(divider_cancel),
    .divider_signed(divider_signed), .divider_dividend(divider_dividend),
    .divider_divisor(divider_divisor), .divider_done(divider_done),
    .divider_quotient(divider_quotient), .divider_remainder(divider_remainder),
    .hi(hi), .lo(lo)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Returns {remainder, quotient}; divide by zero gives all-ones quotient, dividend remainder.
  function automatic logic [63:0] div_ref(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint qa, ra;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      qa = longint'($signed(a)) / longint'($signed(b));
      ra = longint'($signed(a)) % longint'($signed(b));
    end else begin
      qa = longint'({32'd0, a}) / longint'({32'd0, b});
      ra = longint'({32'd0, a}) % longint'({32'd0, b});
    end
    return {ra[31:0], qa[31:0]};
  endfunction

  // Multiplier unit: full-width product of whatever operands the scheduler latched.
  always_comb begin
    if (multiplier_signed)
      multiplier_result = {{W{multiplier_source1[W-1]}}, multiplier_source1} *
                          {{W{multiplier_source2[W-1]}}, multiplier_source2};
    else
      multiplier_result = {{W{1'b0}}, multiplier_source1} * {{W{1'b0}}, multiplier_source2};
  end

  // Divider unit: done is high in the div_lat-th cycle counting the start cycle as the first.
  int          div_lat = 4;
  logic        env_busy;
  int          env_elapsed;
  logic [31:0] env_q, env_r;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      env_busy <= 1'b0; env_elapsed <= 0; env_q <= 32'd0; env_r <= 32'd0;
    end else if (divider_start) begin
      env_busy <= 1'b1; env_elapsed <= 1;
      {env_r, env_q} <= div_ref(divider_signed, divider_dividend, divider_divisor);
    end else if (divider_cancel || divider_done) begin
      env_busy <= 1'b0;
    end else if (env_busy) begin
      env_elapsed <= env_elapsed + 1;
    end
  end
  assign divider_done      = env_busy && (env_elapsed == div_lat - 1);
  assign divider_quotient  = env_q;
  assign divider_remainder = env_r;

  // Reference model: architectural HI/LO plus at most one outstanding operation.
  logic [31:0] m_hi, m_lo, m_res_hi, m_res_lo;
  logic        m_busy, m_is_div, m_just_done;
  int          m_deadline;
  logic        e_mvalid, e_msigned, e_dstart, e_dsigned, e_dcancel;
  logic [31:0] e_ms1, e_ms2, e_dd, e_dv;
  logic        last_exp_stall;

  logic        obs_stall, obs_mvalid, obs_msigned, obs_dstart, obs_dsigned, obs_dcancel;
  logic [31:0] obs_hi, obs_lo, obs_move;

  task automatic reset_model();
    m_hi = 32'd0; m_lo = 32'd0; m_res_hi = 32'd0; m_res_lo = 32'd0;
    m_busy = 1'b0; m_is_div = 1'b0; m_just_done = 1'b0; m_deadline = 0;
    e_mvalid = 1'b0; e_msigned = 1'b0; e_dstart = 1'b0; e_dsigned = 1'b0; e_dcancel = 1'b0;
    e_ms1 = 32'd0; e_ms2 = 32'd0; e_dd = 32'd0; e_dv = 32'd0;
    last_exp_stall = 1'b0;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive at the falling edge, compare against the model, advance the model.
  task automatic step(input logic v, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic f);
    logic        exp_stall, n_mv, n_ds, n_dc, sgn;
    logic [63:0] prod;
    @(negedge clock);
    request_valid = v; request_op = op; source1 = a; source2 = b; flush = f;
    #1;
    obs_stall = stall; obs_mvalid = multiplier_valid; obs_msigned = multiplier_signed;
    obs_dstart = divider_start; obs_dsigned = divider_signed; obs_dcancel = divider_cancel;
    obs_hi = hi; obs_lo = lo; obs_move = move_result;
    exp_stall = m_busy || (v && (op < 3'd4) && !f && !m_just_done);
    last_exp_stall = exp_stall;
    check("stall", 64'(stall), 64'(exp_stall));
    check("hi", 64'(hi), 64'(m_hi));
    check("lo", 64'(lo), 64'(m_lo));
    check("multiplier_valid", 64'(multiplier_valid), 64'(e_mvalid));
    check("divider_start", 64'(divider_start), 64'(e_dstart));
    check("divider_cancel", 64'(divider_cancel), 64'(e_dcancel));
    if (e_mvalid) begin
      check("multiplier_signed", 64'(multiplier_signed), 64'(e_msigned));
      check("multiplier_source1", 64'(multiplier_source1), 64'(e_ms1));
      check("multiplier_source2", 64'(multiplier_source2), 64'(e_ms2));
    end
    if (e_dstart) begin
      check("divider_signed", 64'(divider_signed), 64'(e_dsigned));
      check("divider_dividend", 64'(divider_dividend), 64'(e_dd));
      check("divider_divisor", 64'(divider_divisor), 64'(e_dv));
    end
    if (v && op == OP_MFHI) check("move_result_hi", 64'(move_result), 64'(m_hi));
    if (v && op == OP_MFLO) check("move_result_lo", 64'(move_result), 64'(m_lo));
    n_mv = 1'b0; n_ds = 1'b0; n_dc = 1'b0;
    if (!m_busy) begin
      if (v && !f) begin
        if (op < 3'd4) begin
          if (!m_just_done) begin
            sgn      = (op == OP_MULT) || (op == OP_DIV);
            m_busy   = 1'b1;
            m_is_div = (op == OP_DIV) || (op == OP_DIVU);
            if (!m_is_div) begin
              if (sgn) prod = 64'(longint'($signed(a)) * longint'($signed(b)));
              else     prod = {32'd0, a} * {32'd0, b};
              m_res_hi = prod[63:32]; m_res_lo = prod[31:0];
              m_deadline = cyc + LAT;
              n_mv = 1'b1; e_msigned = sgn; e_ms1 = a; e_ms2 = b;
            end else begin
              {m_res_hi, m_res_lo} = div_ref(sgn, a, b);
              n_ds = 1'b1; e_dsigned = sgn; e_dd = a; e_dv = b;
            end
          end
        end else if (op == OP_MTHI) begin
          m_hi = a;
        end else if (op == OP_MTLO) begin
          m_lo = a;
        end
      end
      m_just_done = 1'b0;
    end else if (f) begin
      n_dc = m_is_div; m_busy = 1'b0; m_just_done = 1'b0;
    end else if ((!m_is_div && cyc == m_deadline) || (m_is_div && divider_done)) begin
      m_hi = m_res_hi; m_lo = m_res_lo; m_busy = 1'b0; m_just_done = 1'b1;
    end
    e_mvalid = n_mv; e_dstart = n_ds; e_dcancel = n_dc;
    cyc++;
  endtask

  typedef struct {
    logic        v;
    logic [2:0]  op;
    logic [31:0] s1;
    logic        f;
    logic        e_stall;
    logic        chk_move;
    logic [31:0] e_move;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
  } vec_t;
  vec_t tbl [10];

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int          pulses, stall_cnt;
    logic        consumed, cur_v, f;
    logic [2:0]  cur_op;
    logic [31:0] cur_a, cur_b;

    tbl[0] = '{1'b1, OP_MTHI, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'h0, 32'h1234_5678, 32'h0};
    tbl[1] = '{1'b1, OP_MFHI, 32'h0,         1'b0, 1'b0, 1'b1, 32'h1234_5678, 32'h1234_5678, 32'h0};
    tbl[2] = '{1'b1, OP_MTLO, 32'h5,         1'b1, 1'b0, 1'b0, 32'h0, 32'h1234_5678, 32'h0};
    tbl[3] = '{1'b1, OP_MTLO, 32'hA5A5_A5A5, 1'b0, 1'b0, 1'b0, 32'h0, 32'h1234_5678, 32'hA5A5_A5A5};
    tbl[4] = '{1'b1, OP_MFLO, 32'h0,         1'b0, 1'b0, 1'b1, 32'hA5A5_A5A5, 32'h1234_5678, 32'hA5A5_A5A5};
    tbl[5] = '{1'b1, OP_MULT, 32'h7,         1'b1, 1'b0, 1'b0, 32'h0, 32'h1234_5678, 32'hA5A5_A5A5};
    tbl[6] = '{1'b0, OP_MTHI, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'h0, 32'h1234_5678, 32'hA5A5_A5A5};
    tbl[7] = '{1'b1, OP_MFHI, 32'h0,         1'b1, 1'b0, 1'b1, 32'h1234_5678, 32'h1234_5678, 32'hA5A5_A5A5};
    tbl[8] = '{1'b1, OP_DIVU, 32'h9,         1'b1, 1'b0, 1'b0, 32'h0, 32'h1234_5678, 32'hA5A5_A5A5};
    tbl[9] = '{1'b1, OP_MTHI, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hA5A5_A5A5};

    reset_model();
    reset_n = 1'b0; request_valid = 1'b0; request_op = 3'd0;
    source1 = 32'd0; source2 = 32'd0; flush = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    check("reset_hi", 64'(hi), 64'(0));
    check("reset_lo", 64'(lo), 64'(0));
    check("reset_stall", 64'(stall), 64'(0));
    check("reset_multiplier_valid", 64'(multiplier_valid), 64'(0));
    check("reset_divider_start", 64'(divider_start), 64'(0));
    @(negedge clock);
    reset_n = 1'b1;

    // Single-cycle IDLE behaviour: moves, reads and flush suppression.
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].v, tbl[i].op, tbl[i].s1, 32'd0, tbl[i].f);
      check("tbl_stall", 64'(obs_stall), 64'(tbl[i].e_stall));
      if (tbl[i].chk_move) check("tbl_move", 64'(obs_move), 64'(tbl[i].e_move));
      @(posedge clock);
      #1;
      check("tbl_hi", 64'(hi), 64'(tbl[i].e_hi));
      check("tbl_lo", 64'(lo), 64'(tbl[i].e_lo));
      check("tbl_no_mul_issue", 64'(multiplier_valid), 64'(0));
      check("tbl_no_div_issue", 64'(divider_start), 64'(0));
    end

    // MULT -2 * 3: request cycle stalls, then issue cycle T and T+1; consumed without re-issue.
    step(1'b1, OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
    check("mul_request_stall", 64'(obs_stall), 64'(1));
    pulses = 0; stall_cnt = 0; consumed = 1'b0;
    for (int k = 0; k < 10 && !consumed; k++) begin
      step(1'b1, OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
      if (obs_mvalid) begin
        pulses++;
        check("mul_signed", 64'(obs_msigned), 64'(1));
      end
      if (obs_stall) stall_cnt++;
      else begin
        consumed = 1'b1;
        check("mul_hi", 64'(obs_hi), 64'(32'hFFFF_FFFF));
        check("mul_lo", 64'(obs_lo), 64'(32'hFFFF_FFFA));
      end
    end
    check("mul_consumed", 64'(consumed), 64'(1));
    check("mul_stall_cycles", 64'(stall_cnt), 64'(LAT));
    for (int k = 0; k < 2; k++) begin
      step(1'b0, OP_MFHI, 32'd0, 32'd0, 1'b0);
      if (obs_mvalid) pulses++;
    end
    check("mul_single_pulse", 64'(pulses), 64'(1));

    // DIVU 100/7 with a 33-cycle divider.
    div_lat = 33;
    step(1'b1, OP_DIVU, 32'd100, 32'd7, 1'b0);
    pulses = 0; stall_cnt = 0; consumed = 1'b0;
    for (int k = 0; k < 50 && !consumed; k++) begin
      step(1'b1, OP_DIVU, 32'd100, 32'd7, 1'b0);
      if (obs_dstart) begin
        pulses++;
        check("divu_signed", 64'(obs_dsigned), 64'(0));
      end
      if (obs_stall) stall_cnt++;
      else begin
        consumed = 1'b1;
        check("divu_lo", 64'(obs_lo), 64'(14));
        check("divu_hi", 64'(obs_hi), 64'(2));
      end
    end
    check("divu_consumed", 64'(consumed), 64'(1));
    check("divu_stall_cycles", 64'(stall_cnt), 64'(33));
    check("divu_single_start", 64'(pulses), 64'(1));

    // Divide by zero: the divider's answer is written unchanged.
    div_lat = 4;
    step(1'b1, OP_DIVU, 32'd50, 32'd0, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b1, OP_DIVU, 32'd50, 32'd0, 1'b0);
    check("div0_hi", 64'(obs_hi), 64'(50));
    check("div0_lo", 64'(obs_lo), 64'(32'hFFFF_FFFF));
    check("div0_stall", 64'(obs_stall), 64'(0));

    // DIV in flight, flushed 10 cycles after start.
    div_lat = 40;
    step(1'b1, OP_DIV, 32'hFFFF_FF9C, 32'd7, 1'b0);
    for (int k = 0; k < 10; k++) step(1'b1, OP_DIV, 32'hFFFF_FF9C, 32'd7, 1'b0);
    step(1'b1, OP_DIV, 32'hFFFF_FF9C, 32'd7, 1'b1);
    step(1'b0, OP_MFHI, 32'd0, 32'd0, 1'b0);
    check("flush_cancel", 64'(obs_dcancel), 64'(1));
    check("flush_idle", 64'(obs_stall), 64'(0));
    check("flush_hi", 64'(obs_hi), 64'(50));
    check("flush_lo", 64'(obs_lo), 64'(32'hFFFF_FFFF));
    step(1'b0, OP_MFHI, 32'd0, 32'd0, 1'b0);
    check("flush_cancel_once", 64'(obs_dcancel), 64'(0));

    // Flush in the same cycle as divider_done: no write.
    div_lat = 5;
    step(1'b1, OP_DIVU, 32'd1000, 32'd10, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b1, OP_DIVU, 32'd1000, 32'd10, 1'b0);
    step(1'b1, OP_DIVU, 32'd1000, 32'd10, 1'b1);
    step(1'b0, OP_MFLO, 32'd0, 32'd0, 1'b0);
    check("coincide_hi", 64'(obs_hi), 64'(50));
    check("coincide_lo", 64'(obs_lo), 64'(32'hFFFF_FFFF));
    check("coincide_cancel", 64'(obs_dcancel), 64'(1));
    step(1'b1, OP_MTLO, 32'd5, 32'd0, 1'b1);
    step(1'b0, OP_MFLO, 32'd0, 32'd0, 1'b0);
    check("mtlo_flushed", 64'(obs_lo), 64'(32'hFFFF_FFFF));

    // Random EX traffic: the held instruction advances when not stalled or on flush.
    cur_v = 1'b0; cur_op = 3'd0; cur_a = 32'd0; cur_b = 32'd0;
    for (int n = 0; n < 1500; n++) begin
      f = ($urandom_range(0, 15) == 0);
      step(cur_v, cur_op, cur_a, cur_b, f);
      if (f || !last_exp_stall) begin
        cur_v  = ($urandom_range(0, 3) != 0);
        cur_op = 3'($urandom_range(0, 7));
        cur_a  = pick();
        cur_b  = pick();
        if (!env_busy && !m_busy) div_lat = $urandom_range(2, 10);
      end
    end

    // Reset asserted while a multiply is being issued.
    step(1'b1, OP_MULT, 32'd3, 32'd5, 1'b0);
    @(negedge clock);
    reset_n = 1'b0; request_valid = 1'b0; flush = 1'b0;
    #1;
    check("midreset_hi", 64'(hi), 64'(0));
    check("midreset_lo", 64'(lo), 64'(0));
    check("midreset_stall", 64'(stall), 64'(0));
    check("midreset_multiplier_valid", 64'(multiplier_valid), 64'(0));
    reset_model();
    @(negedge clock);
    reset_n = 1'b1;
    step(1'b1, OP_MTHI, 32'hCAFE_F00D, 32'd0, 1'b0);
    step(1'b1, OP_MFHI, 32'd0, 32'd0, 1'b0);
    check("post_reset_move", 64'(obs_move), 64'(32'hCAFE_F00D));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
